// File: rtl/row_serializer_16x256.sv
// Row serializer for the 16:1 256-bit row allocator.
// Walks ADDRESS through rows 0..15, captures each selected row and streams it
// out as WORD_W-bit words over valid/ready, MSB word first, row 0 first.
module row_serializer_16x256 #(
  parameter int WORD_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [255:0]      ROW_IN,
  output logic [3:0]        ADDRESS,
  output logic [WORD_W-1:0] DATA_OUT,
  output logic              VALID,
  input  logic              READY,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int WORDS = 256 / WORD_W;
  localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);

  if (WORD_W != 1 && WORD_W != 2 && WORD_W != 4 && WORD_W != 8 &&
      WORD_W != 16 && WORD_W != 32 && WORD_W != 64 && WORD_W != 128 &&
      WORD_W != 256) begin : g_bad_word_w
    $error("row_serializer_16x256: WORD_W must be a power of two from 1 to 256");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t       state;
  logic [255:0] shift_reg;
  logic [3:0]   row_cnt;
  logic [7:0]   word_cnt;
  logic         handshake;

  // The current word is always the top slice of the shift register, so it
  // holds steady until a handshake shifts the next word up.
  assign DATA_OUT  = shift_reg[255 -: WORD_W];
  assign handshake = VALID & READY;

  // Frame sequencer: row addressing, row capture, word shifting and status.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      ADDRESS    <= 4'd0;
      VALID      <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      shift_reg  <= '0;
      row_cnt    <= 4'd0;
      word_cnt   <= 8'd0;
    end else if (ABORT && state != IDLE) begin
      // Cancel wins over a same-cycle handshake: that word is not consumed.
      state      <= IDLE;
      VALID      <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state   <= LOAD;
            ADDRESS <= 4'd0;
            row_cnt <= 4'd0;
            BUSY    <= 1'b1;
          end
        end
        LOAD: begin
          // ADDRESS was registered a cycle earlier, so ROW_IN is settled here.
          shift_reg <= ROW_IN;
          word_cnt  <= 8'd0;
          VALID     <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (handshake) begin
            if (word_cnt == LAST_WORD) begin
              VALID <= 1'b0;
              if (row_cnt == 4'd15) begin
                state      <= DONE;
                FRAME_DONE <= 1'b1;
              end else begin
                ADDRESS <= ADDRESS + 4'd1;
                row_cnt <= row_cnt + 4'd1;
                state   <= LOAD;
              end
            end else begin
              shift_reg <= shift_reg << WORD_W;
              word_cnt  <= word_cnt + 8'd1;
            end
          end
        end
        DONE: begin
          // ADDRESS stays at 15 until the next frame request.
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          VALID <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_serializer_16x256.sv
// Directed bench for row_serializer_16x256: a WORD_W=16 instance for the
// frame, backpressure, isolation, abort and reset scenarios, plus a WORD_W=1
// instance for the single-bit frame.
module tb_row_serializer_16x256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort, ready;
  logic [255:0] row_in;
  logic [3:0]   address;
  logic [15:0]  data_out;
  logic         valid, busy, frame_done;

  logic         start1, abort1, ready1;
  logic [255:0] row_in1;
  logic [3:0]   address1;
  logic [0:0]   data_out1;
  logic         valid1, busy1, frame_done1;

  logic [255:0] frame  [16];
  logic [255:0] frame1 [16];
  logic [15:0]  acc    [256];
  bit           garble;
  int           cyc;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  assign row_in1 = frame1[address1];

  row_serializer_16x256 #(.WORD_W(16)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort), .ROW_IN(row_in),
    .ADDRESS(address), .DATA_OUT(data_out), .VALID(valid), .READY(ready),
    .BUSY(busy), .FRAME_DONE(frame_done)
  );

  row_serializer_16x256 #(.WORD_W(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .ABORT(abort1), .ROW_IN(row_in1),
    .ADDRESS(address1), .DATA_OUT(data_out1), .VALID(valid1), .READY(ready1),
    .BUSY(busy1), .FRAME_DONE(frame_done1)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge. ROW_IN follows
  // ADDRESS like the allocator, except in garble mode where it is noise in
  // every cycle that is not LOAD (busy, not valid, not done).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (garble && !(busy && !valid && !frame_done)) begin
      for (int i = 0; i < 8; i++) row_in[i*32 +: 32] = $urandom();
    end else begin
      row_in = frame[address];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One frame on the 16-bit instance; accepted words land in acc[].
  task automatic run16(input bit rand_ready, input bit pulse_start, input int abort_at,
                       input int rst_at, input int limit,
                       output int n, output int fd_cnt, output int fd_cyc,
                       output int first_v, output int rises, output int busy_low);
    logic        prev_valid, prev_ready;
    logic [15:0] prev_data;
    bit          stop;
    n = 0; fd_cnt = 0; fd_cyc = -1; first_v = -1; rises = 0; busy_low = -1;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0; stop = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!stop && cyc < limit) begin
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = pulse_start && busy && (cyc % 37 == 5);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 256'(valid), 256'(1));
        check("hold_data", 256'(data_out), 256'(prev_data));
      end
      if (valid && !prev_valid) begin
        rises++;
        if (first_v < 0) first_v = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        check("done_after_last", 256'(n), 256'(256));
      end
      if (!busy) begin
        busy_low = cyc;
        stop = 1;
      end else if (valid && n == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 256'(valid), 256'(0));
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_done", 256'(frame_done), 256'(0));
        stop = 1;
      end else if (valid && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("arst_address", 256'(address), 256'(0));
        check("arst_data", 256'(data_out), 256'(0));
        check("arst_valid", 256'(valid), 256'(0));
        check("arst_busy", 256'(busy), 256'(0));
        check("arst_done", 256'(frame_done), 256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          tick();
          if (frame_done) fd_cnt++;
        end
        check("arst_idle", 256'(busy), 256'(0));
        stop = 1;
      end else begin
        if (valid && ready) begin
          check("address", 256'(address), 256'(n / 16));
          if (n < 256) acc[n] = data_out;
          n++;
        end
        prev_valid = valid;
        prev_ready = ready;
        prev_data  = data_out;
        tick();
      end
    end
    check("terminated", 256'(stop), 256'(1));
    start = 1'b0;
    ready = 1'b1;
  endtask

  // kind 0: every byte of row r equals r, so word n is {r,r} with r = n/16.
  // kind 1: only row 3 is non-zero, 0x8000 at its top and 0x0001 at its bottom.
  task automatic check_words(input int kind);
    logic [15:0] e;
    for (int n = 0; n < 256; n++) begin
      if (kind == 0) e = {8'(n / 16), 8'(n / 16)};
      else if (n == 48) e = 16'h8000;
      else if (n == 63) e = 16'h0001;
      else e = 16'h0000;
      check($sformatf("word%0d", n), 256'(acc[n]), 256'(e));
    end
  endtask

  task automatic load_byte_frame();
    for (int r = 0; r < 16; r++) frame[r] = {32{8'(r)}};
  endtask

  initial begin
    int n, fd_cnt, fd_cyc, first_v, rises, busy_low;
    int n1, fd1_cnt, fd1_cyc, first1, busy1_low;
    logic e1;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1; garble = 0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1; cyc = 0;
    load_byte_frame();
    for (int r = 0; r < 16; r++) frame1[r] = {4'(r), 248'd0, 4'b1001};
    row_in = frame[0];

    // Reset state
    idle(3);
    check("rst_address", 256'(address), 256'(0));
    check("rst_data", 256'(data_out), 256'(0));
    check("rst_valid", 256'(valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(frame_done), 256'(0));
    check("rst1_data", 256'(data_out1), 256'(0));
    check("rst1_valid", 256'(valid1), 256'(0));
    rst_n = 1'b1;
    abort = 1'b1;
    idle(2);
    abort = 1'b0;
    check("idle_abort_busy", 256'(busy), 256'(0));

    // Full frame, READY high
    run16(0, 0, -1, -1, 400, n, fd_cnt, fd_cyc, first_v, rises, busy_low);
    check("s1_count", 256'(n), 256'(256));
    check("s1_first_valid", 256'(first_v), 256'(2));
    check("s1_valid_rises", 256'(rises), 256'(16));
    check("s1_done_pulses", 256'(fd_cnt), 256'(1));
    check("s1_done_cycle", 256'(fd_cyc), 256'(273));
    check("s1_busy_low", 256'(busy_low), 256'(274));
    check("s1_address_end", 256'(address), 256'(15));
    check_words(0);
    idle(3);

    // Random backpressure
    run16(1, 0, -1, -1, 3000, n, fd_cnt, fd_cyc, first_v, rises, busy_low);
    check("s2_count", 256'(n), 256'(256));
    check("s2_done_pulses", 256'(fd_cnt), 256'(1));
    check_words(0);
    idle(3);

    // Row isolation with ROW_IN noise outside LOAD
    for (int r = 0; r < 16; r++) frame[r] = '0;
    frame[3] = {16'h8000, 224'd0, 16'h0001};
    garble = 1;
    run16(0, 0, -1, -1, 400, n, fd_cnt, fd_cyc, first_v, rises, busy_low);
    garble = 0;
    check("s3_count", 256'(n), 256'(256));
    check_words(1);
    load_byte_frame();
    idle(3);

    // Abort at row 7 word 5 (word 117) with READY high, then restart
    run16(0, 0, 117, -1, 400, n, fd_cnt, fd_cyc, first_v, rises, busy_low);
    check("s4_accepted", 256'(n), 256'(117));
    check("s4_no_done", 256'(fd_cnt), 256'(0));
    idle(3);
    check("s4_no_late_done", 256'(frame_done), 256'(0));
    run16(0, 0, -1, -1, 400, n, fd_cnt, fd_cyc, first_v, rises, busy_low);
    check("s4r_count", 256'(n), 256'(256));
    check("s4r_first_valid", 256'(first_v), 256'(2));
    check("s4r_done_cycle", 256'(fd_cyc), 256'(273));
    check_words(0);
    idle(3);

    // START pulses while busy have no effect
    run16(0, 1, -1, -1, 400, n, fd_cnt, fd_cyc, first_v, rises, busy_low);
    check("s5_count", 256'(n), 256'(256));
    check("s5_done_pulses", 256'(fd_cnt), 256'(1));
    check("s5_done_cycle", 256'(fd_cyc), 256'(273));
    check_words(0);
    idle(3);

    // Asynchronous reset in row 10 (word 163)
    run16(0, 0, -1, 163, 400, n, fd_cnt, fd_cyc, first_v, rises, busy_low);
    check("s5r_accepted", 256'(n), 256'(163));
    check("s5r_no_done", 256'(fd_cnt), 256'(0));
    idle(3);

    // Single-bit words: row r = {r[3:0], 248 zeros, 1001}
    n1 = 0; fd1_cnt = 0; fd1_cyc = -1; first1 = -1; busy1_low = -1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1;
    while (cyc < 4300 && !(cyc > 1 && !busy1)) begin
      if (valid1 && first1 < 0) first1 = cyc;
      if (frame_done1) begin
        fd1_cnt++;
        fd1_cyc = cyc;
      end
      if (valid1 && ready1) begin
        if (n1 % 256 < 4) e1 = 1'(((n1 / 256) >> (3 - n1 % 256)) & 1);
        else if (n1 % 256 == 252 || n1 % 256 == 255) e1 = 1'b1;
        else e1 = 1'b0;
        check($sformatf("bit%0d", n1), 256'(data_out1), 256'(e1));
        if (n1 % 256 == 0) check("w1_address", 256'(address1), 256'(n1 / 256));
        n1++;
      end
      tick();
    end
    busy1_low = busy1 ? -1 : cyc;
    check("w1_count", 256'(n1), 256'(4096));
    check("w1_first_valid", 256'(first1), 256'(2));
    check("w1_done_pulses", 256'(fd1_cnt), 256'(1));
    // Last bit is accepted at cycle 4112; the done pulse follows it.
    check("w1_done_cycle", 256'(fd1_cyc), 256'(4113));
    check("w1_busy_low", 256'(busy1_low), 256'(4114));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
